// File: rtl/axi_pkg.sv
// Shared AXI read-path definitions: state encoding, response codes, default widths.
`ifndef YSYX_23060251_AXI_ADDR
`define YSYX_23060251_AXI_ADDR 32
`endif
`ifndef YSYX_23060251_AXI_DATA
`define YSYX_23060251_AXI_DATA 32
`endif

package axi_pkg;

    localparam int AXI_ADDR_W = `YSYX_23060251_AXI_ADDR;
    localparam int AXI_DATA_W = `YSYX_23060251_AXI_DATA;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // One-hot read arbiter states
    typedef enum logic [2:0] {
        RD_IDLE = 3'b001,
        RD_ADDR = 3'b010,
        RD_DATA = 3'b100
    } rd_arb_state_t;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-input round-robin picker. Remembers the last served requester and
// favours the other one when both request in the same cycle.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       upd_en_i,
    input  logic       upd_grant_i,
    output logic       pick_o
);

    logic last_grant_q;
    logic last_grant_d;

    // Capture the served requester when the owner's transaction completes
    always_comb begin
        last_grant_d = last_grant_q;
        if (upd_en_i) begin
            last_grant_d = upd_grant_i;
        end
    end

    // Reset to 1 so requester 0 wins the first tie
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Lone requester wins outright; a tie goes to the one not served last
    always_comb begin
        pick_o = 1'b0;
        case (req_i)
            2'b01:   pick_o = 1'b0;
            2'b10:   pick_o = 1'b1;
            2'b11:   pick_o = ~last_grant_q;
            default: pick_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// AXI4-Lite read-channel arbiter: shares one downstream AR/R port between the
// IFU (m0) and the LSU (m1), one outstanding transaction at a time.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_ar_valid,
    output logic              m0_ar_ready,
    input  logic [ADDR_W-1:0] m0_ar_addr,
    output logic              m0_r_valid,
    input  logic              m0_r_ready,
    output logic [DATA_W-1:0] m0_r_data,
    output logic [1:0]        m0_r_resp,

    input  logic              m1_ar_valid,
    output logic              m1_ar_ready,
    input  logic [ADDR_W-1:0] m1_ar_addr,
    output logic              m1_r_valid,
    input  logic              m1_r_ready,
    output logic [DATA_W-1:0] m1_r_data,
    output logic [1:0]        m1_r_resp,

    output logic              s_ar_valid,
    input  logic              s_ar_ready,
    output logic [ADDR_W-1:0] s_ar_addr,
    input  logic              s_r_valid,
    output logic              s_r_ready,
    input  logic [DATA_W-1:0] s_r_data,
    input  logic [1:0]        s_r_resp,

    output logic              busy_o,
    output logic              grant_o
);

    rd_arb_state_t     state_q, state_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pick;
    logic              upd_en;
    logic              r_ready_sel;

    rr_arb2 u_rr_arb2 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       ({m1_ar_valid, m0_ar_valid}),
        .upd_en_i    (upd_en),
        .upd_grant_i (grant_q),
        .pick_o      (pick)
    );

    // State, grant index and latched address; in-flight work is dropped on reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RD_IDLE;
            grant_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
        end
    end

    // Next state and channel routing; everything idles at 0 unless a state drives it
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        upd_en      = 1'b0;
        r_ready_sel = 1'b0;
        m0_ar_ready = 1'b0;
        m1_ar_ready = 1'b0;
        s_ar_valid  = 1'b0;
        s_r_ready   = 1'b0;
        m0_r_valid  = 1'b0;
        m0_r_data   = '0;
        m0_r_resp   = AXI_RESP_OKAY;
        m1_r_valid  = 1'b0;
        m1_r_data   = '0;
        m1_r_resp   = AXI_RESP_OKAY;

        unique case (state_q)
            RD_IDLE: begin
                // ar_ready is combinational from ar_valid but held low during reset
                if (!rst_i && (m0_ar_valid || m1_ar_valid)) begin
                    if (pick) begin
                        m1_ar_ready = 1'b1;
                        addr_d      = m1_ar_addr;
                    end else begin
                        m0_ar_ready = 1'b1;
                        addr_d      = m0_ar_addr;
                    end
                    grant_d = pick;
                    state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                s_ar_valid = 1'b1;
                if (s_ar_ready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (grant_q) begin
                    m1_r_valid  = s_r_valid;
                    m1_r_data   = s_r_data;
                    m1_r_resp   = s_r_resp;
                    r_ready_sel = m1_r_ready;
                end else begin
                    m0_r_valid  = s_r_valid;
                    m0_r_data   = s_r_data;
                    m0_r_resp   = s_r_resp;
                    r_ready_sel = m0_r_ready;
                end
                s_r_ready = r_ready_sel;
                if (s_r_valid && r_ready_sel) begin
                    upd_en  = 1'b1;
                    state_d = RD_IDLE;
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    assign busy_o    = (state_q != RD_IDLE);
    assign grant_o   = grant_q;
    assign s_ar_addr = addr_q;

endmodule
